// File: rtl/vector_readout_pkg.sv
// -----------------------------------------------------------------------------
// vector_readout_pkg
// Shared types and default sizes for the vector readout block, which unloads
// one register-file vector as a stream of fp32 words.
//   state_t            : controller state (IDLE, FETCH, STREAM)
//   *_DEF localparams  : default vector, address, word and count widths
// -----------------------------------------------------------------------------
package vector_readout_pkg;

  localparam int DATA_WIDTH_DEF = 512;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int WORD_WIDTH_DEF = 32;
  localparam int MAX_WORDS_DEF  = DATA_WIDTH_DEF / WORD_WIDTH_DEF;
  localparam int CNT_WIDTH_DEF  = $clog2(MAX_WORDS_DEF + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2
  } state_t;

endpackage

// File: rtl/vector_readout_if.sv
// -----------------------------------------------------------------------------
// vector_readout_if
// Bundles the command handshake, register-file read port and output word
// stream of the vector readout block.
//   cmd_valid/cmd_ready/cmd_addr/cmd_num_words : request from the sequencer
//   rf_addr/rf_data                            : register-file read port
//   out_valid/out_ready/out_data/out_last      : word stream to the host side
//   busy/done                                  : status
// Modports: slave = the readout block, master = its environment.
// -----------------------------------------------------------------------------
interface vector_readout_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 5,
  parameter int WORD_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [CNT_WIDTH-1:0]  cmd_num_words;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0] rf_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_num_words,
    output cmd_ready,
    output rf_addr,
    input  rf_data,
    output out_valid, out_data, out_last,
    input  out_ready,
    output busy, done
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_num_words,
    input  cmd_ready,
    input  rf_addr,
    output rf_data,
    input  out_valid, out_data, out_last,
    output out_ready,
    input  busy, done
  );

endinterface

// File: rtl/vector_readout.sv
// -----------------------------------------------------------------------------
// vector_readout
// Reads one DATA_WIDTH-bit vector from the register file and emits it as
// WORD_WIDTH-bit words on a valid/ready stream, element 0 first.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : vector_readout_if.slave (command, register-file read, word stream,
//          busy/done status)
// Flow: IDLE accepts a command and registers the read address, FETCH spends
// one cycle letting the register file (and its write bypass) settle before
// the vector is captured, STREAM shifts out one word per accepted beat.
// -----------------------------------------------------------------------------
module vector_readout
  import vector_readout_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int MAX_WORDS  = DATA_WIDTH / WORD_WIDTH,
  parameter int CNT_WIDTH  = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  vector_readout_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_WORDS);
  localparam logic [CNT_WIDTH-1:0] ONE_CNT = CNT_WIDTH'(1);

  // A zero count, or one larger than a vector holds, means "whole vector".
  function automatic logic [CNT_WIDTH-1:0] clamp_count(input logic [CNT_WIDTH-1:0] n);
    return ((n == '0) || (n > MAX_CNT)) ? MAX_CNT : n;
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  done_q, done_d;

  logic cmd_ready;
  logic cmd_fire;
  logic word_fire;
  logic last_word;

  // Held low during reset so no request can slip in on the reset edge.
  assign cmd_ready = (state_q == IDLE) & ~rst;
  assign cmd_fire  = bus.cmd_valid & cmd_ready;
  assign last_word = (remaining_q == ONE_CNT);
  assign word_fire = (state_q == STREAM) & bus.out_ready;

  always_comb begin
    state_d     = state_q;
    rf_addr_d   = rf_addr_q;
    shreg_d     = shreg_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          rf_addr_d   = bus.cmd_addr;
          remaining_d = clamp_count(bus.cmd_num_words);
          state_d     = FETCH;
        end
      end
      FETCH: begin
        // rf_data already carries any same-cycle write to rf_addr.
        shreg_d = bus.rf_data;
        state_d = STREAM;
      end
      STREAM: begin
        if (word_fire) begin
          shreg_d     = shreg_q >> WORD_WIDTH;
          remaining_d = remaining_q - ONE_CNT;
          if (last_word) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rf_addr_q   <= '0;
      shreg_q     <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rf_addr_q   <= rf_addr_d;
      shreg_q     <= shreg_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rf_addr   = rf_addr_q;
  assign bus.out_valid = (state_q == STREAM);
  // Word output is forced to zero outside STREAM so idle leftovers never show.
  assign bus.out_data  = (state_q == STREAM) ? shreg_q[WORD_WIDTH-1:0] : '0;
  assign bus.out_last  = (state_q == STREAM) & last_word;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_vector_readout.sv
// -----------------------------------------------------------------------------
// tb_vector_readout
// Bench for vector_readout: a register-file model with write bypass, command
// stimulus that pushes expected words into a scoreboard, and an independent
// monitor that pops and compares every accepted word and watches the stream
// handshake and done pulse.
// -----------------------------------------------------------------------------
module tb_vector_readout;
  import vector_readout_pkg::*;

  localparam int DW = 512;
  localparam int AW = 5;
  localparam int WW = 32;
  localparam int MW = DW / WW;
  localparam int CW = $clog2(MW + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vector_readout_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .CNT_WIDTH(CW)) bus ();

  vector_readout #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register file with write bypass on the read port.
  logic [DW-1:0] mem [32];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  assign bus.rf_data = (wr_en && (wr_addr == bus.rf_addr)) ? wr_data : mem[bus.rf_addr];

  typedef struct packed {
    logic [WW-1:0] data;
    logic          last;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  function void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    for (int k = 0; k < MW; k++) v[k*WW +: WW] = $urandom;
    return v;
  endfunction

  // Consumer ready: 0 = always ready, 1 = fixed stall pattern, 2 = random.
  int ready_mode = 0;
  int pat_idx    = 0;
  int pat [6]    = '{1, 0, 0, 1, 0, 1};
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: begin
          bus.out_ready = (pat[pat_idx % 6] != 0);
          pat_idx++;
        end
        2:       bus.out_ready = ($urandom_range(0, 2) != 0);
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: scoreboard pops, stall stability, done-pulse timing.
  initial begin
    logic          pv, pr, pl, plast_acc, prst;
    logic [WW-1:0] pd;
    bit            started;
    exp_t          e;
    started = 0;
    pv = 0; pr = 0; pl = 0; plast_acc = 0; prst = 1; pd = '0;
    forever begin
      @(negedge clk);
      if (started) begin
        check("done_pulse", bus.done, plast_acc && !prst);
        if (pv && !pr && !prst) begin
          check("stall_valid", bus.out_valid, 1);
          check("stall_data", bus.out_data, pd);
          check("stall_last", bus.out_last, pl);
        end
      end
      if (bus.out_valid && bus.out_ready && !rst) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", bus.out_data);
        end else begin
          e = sb_q.pop_front();
          check("word_data", bus.out_data, e.data);
          check("word_last", bus.out_last, e.last);
        end
      end
      pv        = bus.out_valid;
      pr        = bus.out_ready;
      pl        = bus.out_last;
      pd        = bus.out_data;
      plast_acc = bus.out_valid & bus.out_ready & bus.out_last;
      prst      = rst;
      started   = 1;
    end
  end

  // Issue one command; expected words come from the register-file contents
  // as they will be at the end of FETCH (including a planned bypass write).
  task automatic accept_cmd(input logic [AW-1:0] a, input logic [CW-1:0] n,
                            input bit keep, input bit chk_done,
                            input bit byp, input logic [DW-1:0] bv);
    int            cyc;
    int            neff;
    logic [DW-1:0] vec;
    exp_t          e;
    @(posedge clk);
    #1;
    bus.cmd_valid     = 1'b1;
    bus.cmd_addr      = a;
    bus.cmd_num_words = n;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.cmd_ready && cyc < 200);
    if (!bus.cmd_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%0b, expected 1", bus.cmd_ready);
      bus.cmd_valid = 1'b0;
      return;
    end
    if (chk_done) check("accept_in_done_cycle", bus.done, 1);
    neff = ((n == 0) || (n > MW)) ? MW : int'(n);
    vec  = byp ? bv : mem[a];
    for (int k = 0; k < neff; k++) begin
      e.data = vec[k*WW +: WW];
      e.last = (k == neff - 1);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!keep) bus.cmd_valid = 1'b0;
    if (byp) begin
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = bv;
    end
    @(negedge clk);
    check("fetch_out_valid", bus.out_valid, 0);
    check("fetch_busy", bus.busy, 1);
    check("fetch_cmd_ready", bus.cmd_ready, 0);
    check("fetch_rf_addr", bus.rf_addr, a);
    @(posedge clk);
    #1;
    if (byp) begin
      mem[a] = bv;
      wr_en  = 1'b0;
    end
    @(negedge clk);
    check("first_valid_at_T2", bus.out_valid, 1);
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while ((bus.busy || sb_q.size() != 0) && cyc < 2000);
    if (bus.busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy=%0b, expected 0", bus.busy);
    end
    check("scoreboard_drained", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] bv;
    logic [AW-1:0] ra;
    logic [CW-1:0] rn;
    bit            rb;

    bus.cmd_valid     = 1'b0;
    bus.cmd_addr      = '0;
    bus.cmd_num_words = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < 32; i++) mem[i] = rand_vec();
    mem[2][0*WW +: WW]  = 32'hb8cbffed;
    mem[2][1*WW +: WW]  = 32'h38a36038;
    mem[2][2*WW +: WW]  = 32'h3b6d8000;
    mem[16][0*WW +: WW] = 32'h3f800000;
    mem[16][1*WW +: WW] = 32'h358efa35;
    mem[16][2*WW +: WW] = 32'h388e4000;
    for (int k = 9; k < MW; k++) mem[16][k*WW +: WW] = '0;
    mem[19][0*WW +: WW] = 32'h3ba3d70a;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rf_addr", bus.rf_addr, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", bus.cmd_ready, 1);

    // Three words from addr 2
    accept_cmd(5'd2, 5'd3, 0, 0, 0, '0);
    wait_idle();
    repeat (3) @(negedge clk);
    check("rf_addr_holds", bus.rf_addr, 2);

    // Full vector via count 0
    accept_cmd(5'd16, 5'd0, 0, 0, 0, '0);
    wait_idle();

    // Stalls on the consumer side
    pat_idx    = 0;
    ready_mode = 1;
    accept_cmd(5'd2, 5'd3, 0, 0, 0, '0);
    wait_idle();
    ready_mode = 0;

    // Write to the read address during FETCH is captured
    bv = rand_vec();
    bv[0*WW +: WW] = 32'h3f800000;
    bv[1*WW +: WW] = 32'h40400000;
    accept_cmd(5'd2, 5'd4, 0, 0, 1, bv);
    wait_idle();

    // Reset in the middle of a 9-word readout
    accept_cmd(5'd4, 5'd9, 0, 0, 0, '0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_cmd_ready", bus.cmd_ready, 1);
    check("midrst_done", bus.done, 0);
    accept_cmd(5'd19, 5'd1, 0, 0, 0, '0);
    wait_idle();

    // cmd_valid held across two commands: second taken in the done cycle
    accept_cmd(5'd7, 5'd3, 1, 0, 0, '0);
    accept_cmd(5'd9, 5'd2, 0, 1, 0, '0);
    wait_idle();

    // A request pulse during STREAM is not latched
    accept_cmd(5'd5, 5'd4, 0, 0, 0, '0);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 5'd6;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("no_latched_cmd_busy", bus.busy, 0);

    // Randomized commands with random back-pressure and bypass writes
    ready_mode = 2;
    for (int it = 0; it < 25; it++) begin
      ra = AW'($urandom_range(0, 31));
      rn = CW'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0);
      bv = rand_vec();
      accept_cmd(ra, rn, 0, 0, rb, bv);
      wait_idle();
    end
    ready_mode = 0;
    repeat (3) @(negedge clk);
    check("final_scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
